// File: rtl/vend_pkg.sv
// Shared constants for the vending controller and the downstream coin dispenser.
package vend_pkg;

  localparam int unsigned CREDIT_W = 10;
  localparam int unsigned STATE_W  = 2;

  // Coin values in cents; the dispenser pays change using these same values.
  localparam logic [CREDIT_W-1:0] COIN_Q_VAL = 10'd25;
  localparam logic [CREDIT_W-1:0] COIN_D_VAL = 10'd10;
  localparam logic [CREDIT_W-1:0] COIN_N_VAL = 10'd5;

  // Default configuration
  localparam int unsigned PRICE_DEF      = 65;
  localparam int unsigned MAX_CREDIT_DEF = 1000;

  // Controller state encoding
  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_COLLECT  = 2'd1;
  localparam logic [STATE_W-1:0] ST_VEND     = 2'd2;
  localparam logic [STATE_W-1:0] ST_DISPENSE = 2'd3;

  // Decoded coin input for one cycle
  typedef struct packed {
    logic                any;
    logic                multi;
    logic [CREDIT_W-1:0] value;
  } coin_info_t;

endpackage

// File: rtl/vend_controller_coin_value_enc.sv
// Maps the one-hot coin pulses to a cent value plus presence and multi-coin flags.
module coin_value_enc
  import vend_pkg::*;
(
  input  logic       coin_q_i,
  input  logic       coin_d_i,
  input  logic       coin_n_i,
  output coin_info_t coin_o
);

  // Value is only meaningful when exactly one pulse is present.
  always_comb begin
    coin_o       = '0;
    coin_o.any   = coin_q_i | coin_d_i | coin_n_i;
    coin_o.multi = (coin_q_i & coin_d_i) | (coin_q_i & coin_n_i) | (coin_d_i & coin_n_i);
    if (coin_q_i)      coin_o.value = COIN_Q_VAL;
    else if (coin_d_i) coin_o.value = COIN_D_VAL;
    else if (coin_n_i) coin_o.value = COIN_N_VAL;
  end

endmodule

// File: rtl/vend_controller.sv
// Vending machine controller: credit accumulation, vend, refund and change hand-off.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = PRICE_DEF,
  parameter int unsigned MAX_CREDIT = MAX_CREDIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_q,
  input  logic                coin_d,
  input  logic                coin_n,
  input  logic                select,
  input  logic                cancel,
  input  logic                disp_done,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                vend,
  output logic                coin_reject,
  output logic                busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  logic [STATE_W-1:0]  state_q,  state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                vend_q,   vend_d;
  logic                reject_q, reject_d;
  logic                busy_q,   busy_d;

  coin_info_t          coin;
  logic [SUM_W-1:0]    sum;
  logic                over_limit;
  logic                take_cancel;
  logic                take_select;

  coin_value_enc u_enc (
    .coin_q_i (coin_q),
    .coin_d_i (coin_d),
    .coin_n_i (coin_n),
    .coin_o   (coin)
  );

  // One bit of headroom so the ceiling check cannot wrap.
  assign sum         = SUM_W'(credit_q) + SUM_W'(coin.value);
  assign over_limit  = sum > SUM_W'(MAX_CREDIT);
  assign take_cancel = (state_q == ST_COLLECT) && cancel;
  assign take_select = (state_q == ST_COLLECT) && select && !cancel &&
                       (credit_q >= CREDIT_W'(PRICE));

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    vend_d   = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        reject_d = coin.any & (coin.multi | over_limit | take_cancel | take_select);
        if (take_cancel) begin
          state_d  = ST_DISPENSE;
          change_d = credit_q;
        end else if (take_select) begin
          state_d  = ST_VEND;
          vend_d   = 1'b1;
          change_d = credit_q - CREDIT_W'(PRICE);
        end else if (coin.any && !coin.multi && !over_limit) begin
          state_d  = ST_COLLECT;
          credit_d = sum[CREDIT_W-1:0];
        end
      end
      ST_VEND: begin
        reject_d = coin.any;
        if (change_q != '0) begin
          state_d = ST_DISPENSE;
        end else begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end
      end
      ST_DISPENSE: begin
        reject_d = coin.any;
        if (disp_done) begin
          state_d  = ST_IDLE;
          credit_d = '0;
          change_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        change_d = '0;
      end
    endcase
    busy_d = (state_d == ST_VEND) || (state_d == ST_DISPENSE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      change_q <= '0;
      vend_q   <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      vend_q   <= vend_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign change      = change_q;
  assign vend        = vend_q;
  assign coin_reject = reject_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller (PRICE 65, MAX_CREDIT 100).
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_q, coin_d, coin_n, select, cancel, disp_done;
  logic [9:0] credit, change;
  logic       vend, coin_reject, busy;

  int errors = 0;
  int checks = 0;

  vend_controller #(.PRICE(65), .MAX_CREDIT(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_q      (coin_q),
    .coin_d      (coin_d),
    .coin_n      (coin_n),
    .select      (select),
    .cancel      (cancel),
    .disp_done   (disp_done),
    .credit      (credit),
    .change      (change),
    .vend        (vend),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for one rising edge; returns at the following falling edge.
  task automatic step(input logic r, input logic q, input logic d, input logic n,
                      input logic sel, input logic can, input logic done);
    rst = r; coin_q = q; coin_d = d; coin_n = n;
    select = sel; cancel = can; disp_done = done;
    @(negedge clk);
    rst = 1'b0; coin_q = 1'b0; coin_d = 1'b0; coin_n = 1'b0;
    select = 1'b0; cancel = 1'b0; disp_done = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic outs(input string tag, input int c, input int ch,
                      input int v, input int rj, input int b);
    check({tag, ".credit"}, int'(credit), c);
    check({tag, ".change"}, int'(change), ch);
    check({tag, ".vend"},   int'(vend), v);
    check({tag, ".reject"}, int'(coin_reject), rj);
    check({tag, ".busy"},   int'(busy), b);
  endtask

  initial begin
    rst = 1'b1; coin_q = 0; coin_d = 0; coin_n = 0;
    select = 0; cancel = 0; disp_done = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    outs("reset", 0, 0, 0, 0, 0);

    // Cancel and disp_done in IDLE are ignored
    step(0, 0, 0, 0, 0, 1, 0);
    outs("idle_cancel", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    outs("idle_done", 0, 0, 0, 0, 0);

    // Purchase with change: Q Q D, select at 60 ignored, D, select
    step(0, 1, 0, 0, 0, 0, 0); check("t1.q1", int'(credit), 25);
    step(0, 1, 0, 0, 0, 0, 0); check("t1.q2", int'(credit), 50);
    step(0, 0, 1, 0, 0, 0, 0); check("t1.d1", int'(credit), 60);
    step(0, 0, 0, 0, 1, 0, 0);
    outs("t1.sel60", 60, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0); check("t1.d2", int'(credit), 70);
    step(0, 0, 0, 0, 1, 0, 0);
    outs("t1.vend", 70, 5, 1, 0, 1);
    idle();
    outs("t1.disp", 70, 5, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 0);
    outs("t1.selcan_in_disp", 70, 5, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    outs("t1.coin_in_disp", 70, 5, 0, 1, 1);
    idle();
    outs("t1.hold", 70, 5, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    outs("t1.done", 0, 0, 0, 0, 0);

    // Exact pay: Q Q D N = 65, no DISPENSE
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0); check("t2.credit65", int'(credit), 65);
    step(0, 0, 0, 0, 1, 0, 0);
    outs("t2.vend", 65, 0, 1, 0, 1);
    idle();
    outs("t2.idle", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    outs("t2.stray_done", 0, 0, 0, 0, 0);

    // Cancel at 35
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0); check("t3.credit35", int'(credit), 35);
    step(0, 0, 0, 0, 0, 1, 0);
    outs("t3.cancel", 35, 35, 0, 0, 1);
    idle();
    idle();
    outs("t3.wait", 35, 35, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    outs("t3.done", 0, 0, 0, 0, 0);

    // Credit ceiling and multi-coin rejects
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0);
    check("t4.credit100", int'(credit), 100);
    step(0, 0, 0, 1, 0, 0, 0);
    outs("t4.over", 100, 0, 0, 1, 0);
    idle();
    check("t4.reject_pulse", int'(coin_reject), 0);
    step(0, 1, 1, 0, 0, 0, 0);
    outs("t4.multi", 100, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    outs("t4.cleared", 0, 0, 0, 0, 0);

    // Multi-coin in IDLE, then coin together with an accepted select
    step(0, 0, 1, 1, 0, 0, 0);
    outs("t5.multi_idle", 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    // Select and cancel together at 70: cancel wins; coin in same cycle rejected
    step(0, 0, 0, 1, 1, 1, 0);
    outs("t5.selcan", 70, 70, 0, 1, 1);
    idle();
    check("t5.no_vend", int'(vend), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    outs("t5.done", 0, 0, 0, 0, 0);

    // Reset mid-DISPENSE takes priority over a same-cycle disp_done and coin
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle();
    outs("t6.disp", 70, 5, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    outs("t6.reset", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    outs("t6.late_done", 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    outs("t6.fresh_coin", 5, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE, default 65, item price in cents; SHALL be a multiple of 5 and 5..1000.
REQ-002 Parameter MAX_CREDIT, default 1000, credit ceiling in cents; SHALL be 5..1023 and at least PRICE.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 coin_q / coin_d / coin_n  input  1 each  one-cycle pulses: quarter (25), dime (10) and nickel (5) inserted.
REQ-006 select  input  1  one-cycle pulse: purchase request.
REQ-007 cancel  input  1  one-cycle pulse: refund request.
REQ-008 disp_done  input  1  one-cycle pulse from the downstream coin dispenser: change fully paid out.
REQ-009 credit  output  10  current accumulated credit in cents.
REQ-010 change  output  10  amount to dispense, fed to the dispenser's change input; 0 when nothing to pay.
REQ-011 vend  output  1  one-cycle pulse: release item.
REQ-012 coin_reject  output  1  one-cycle pulse: return the inserted coin(s).
REQ-013 busy  output  1  high in the VEND and DISPENSE states.

Function
REQ-014 States: IDLE (credit = 0), COLLECT (credit > 0), VEND, DISPENSE; all outputs registered.
REQ-015 A valid coin (exactly one coin pulse in IDLE/COLLECT) SHALL add its value to credit, visible the next cycle; the state SHALL move to or stay in COLLECT.
REQ-016 A coin SHALL be rejected (coin_reject pulse the next cycle, credit unchanged) in any of these cases: credit + value > MAX_CREDIT; two or more coin pulses in one cycle; the coin arrives in VEND or DISPENSE; or select/cancel is accepted in the same cycle.
REQ-017 Select in COLLECT with credit >= PRICE: the next cycle SHALL be VEND, with vend = 1 and change = credit - PRICE; select with credit < PRICE SHALL be ignored.
REQ-018 VEND lasts exactly one cycle: if change != 0, go to DISPENSE; otherwise go to IDLE with credit = 0.
REQ-019 In DISPENSE, change SHALL be held stable until disp_done. On the cycle after disp_done: change = 0, credit = 0, state IDLE.
REQ-020 Cancel in COLLECT: the next cycle SHALL be DISPENSE with change = credit and vend never asserted; cancel in IDLE SHALL be ignored.
REQ-021 Select and cancel in the same cycle: cancel wins.
REQ-022 Select and cancel in VEND/DISPENSE SHALL be ignored; disp_done outside DISPENSE SHALL be ignored.
REQ-023 Arithmetic SHALL be 10-bit unsigned; the REQ-016 limit check makes overflow and wrap-around impossible.
REQ-024 Credit SHALL remain at its pre-vend value during VEND/DISPENSE and clear only on exit.

Reset
REQ-025 When rst is high at a clock edge, the next cycle SHALL be IDLE with credit = 0, change = 0, vend = 0, coin_reject = 0, busy = 0, from any state, including mid-DISPENSE.
REQ-026 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-027 A shared package vend_pkg SHALL hold the coin value constants (25/10/5), the state encoding and the default PRICE/MAX_CREDIT; the coin dispenser SHALL use the same coin constants.
REQ-028 One sub-module, coin_value_enc (combinational), SHALL map the coin pulses to a 10-bit value plus a multi-coin flag; the FSM and datapath SHALL live in vend_controller.

Verification
REQ-029 PRICE = 65: Q, Q, D, D (credit 70), then select -> vend pulse; change = 5 held until disp_done; next cycle credit = 0 and state IDLE.
REQ-030 Exact pay: Q, Q, D, N (65), then select -> vend pulse; change stays 0 throughout; DISPENSE is never entered; IDLE after one VEND cycle.
REQ-031 Cancel: Q, D (35), then cancel -> change = 35, vend never asserted, busy high until disp_done; afterwards credit = 0.
REQ-032 MAX_CREDIT = 100: four Q (credit 100), then N -> coin_reject pulse, credit stays 100; coin_q and coin_d in the same cycle -> coin_reject pulse, credit unchanged.
REQ-033 Select at credit 60 -> ignored; coin during DISPENSE -> rejected; select and cancel together at credit 70 -> refund change = 70, no vend.
REQ-034 rst asserted mid-DISPENSE (change = 5) -> next cycle all outputs 0 and state IDLE; a later disp_done has no effect.
